// File: rtl/mem_arbiter_2port.sv
// Two-port memory arbiter/sequencer: round-robin grant, one transaction at a
// time, start pulse to memory, wait for done with timeout, ack/err back to the
// granted port, plus saturating access/miss statistics.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req{0,1}_i, wr{0,1}_i        request level and direction (1 = write)
//   addr{0,1}_i, wdata{0,1}_i    operands, held with req until ack/err
//   ack{0,1}_o, err{0,1}_o       one-cycle completion / timeout pulses
//   rdata{0,1}_o                 read data, updated on a read ack
//   mem_start_o                  one-cycle start pulse to memory
//   mem_wr_o, mem_addr_o,        latched operation, stable for the whole
//   mem_data_o                     transaction
//   mem_done_i, mem_rdata_i,     completion pulse with read data and miss flag
//   mem_miss_i
//   clr_stats_i                  synchronous clear of the statistics
//   access_count_o, miss_count_o completed transactions / completed read misses
module mem_arbiter_2port #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          wr0_i,
    input  logic          wr1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          ack0_o,
    output logic          ack1_o,
    output logic          err0_o,
    output logic          err1_o,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o,
    output logic          mem_start_o,
    output logic          mem_wr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    input  logic          mem_done_i,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_miss_i,
    input  logic          clr_stats_i,
    output logic [CW-1:0] access_count_o,
    output logic [CW-1:0] miss_count_o
);

    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [TW-1:0] wcnt_q, wcnt_d;
    logic          miss_cap_q, miss_cap_d;
    logic          mem_start_q, mem_start_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [CW-1:0] acc_q, acc_d, miss_q, miss_d;
    logic          grant;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            wcnt_q      <= '0;
            miss_cap_q  <= 1'b0;
            mem_start_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            acc_q       <= '0;
            miss_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            miss_cap_q  <= miss_cap_d;
            mem_start_q <= mem_start_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            acc_q       <= acc_d;
            miss_q      <= miss_d;
        end
    end

    // Next-state and registered-output logic; pulses are computed one cycle
    // early so they appear in the ISSUE/RESP/ERR cycle itself.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        miss_cap_d  = miss_cap_q;
        mem_start_d = 1'b0;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        acc_d       = acc_q;
        miss_d      = miss_q;
        grant       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0_i || req1_i) begin
                    // Tie goes to the port that was not served last
                    grant       = (req0_i && req1_i) ? ~last_q : req1_i;
                    gnt_d       = grant;
                    mem_wr_d    = grant ? wr1_i    : wr0_i;
                    mem_addr_d  = grant ? addr1_i  : addr0_i;
                    mem_data_d  = grant ? wdata1_i : wdata0_i;
                    mem_start_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d = wcnt_q + TW'(1);
                // done takes priority over a same-cycle timeout
                if (mem_done_i) begin
                    miss_cap_d = mem_miss_i;
                    state_d    = S_RESP;
                    if (gnt_q) begin
                        ack1_d = 1'b1;
                        if (!mem_wr_q) rdata1_d = mem_rdata_i;
                    end else begin
                        ack0_d = 1'b1;
                        if (!mem_wr_q) rdata0_d = mem_rdata_i;
                    end
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                    if (gnt_q) err1_d = 1'b1;
                    else       err0_d = 1'b1;
                end
            end
            S_RESP: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
                if (acc_q != CNT_MAX) acc_d = acc_q + CW'(1);
                if (!mem_wr_q && miss_cap_q && (miss_q != CNT_MAX)) miss_d = miss_q + CW'(1);
            end
            S_ERR: begin
                last_d  = gnt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clr_stats_i) begin
            acc_d  = '0;
            miss_d = '0;
        end
    end

    assign ack0_o         = ack0_q;
    assign ack1_o         = ack1_q;
    assign err0_o         = err0_q;
    assign err1_o         = err1_q;
    assign rdata0_o       = rdata0_q;
    assign rdata1_o       = rdata1_q;
    assign mem_start_o    = mem_start_q;
    assign mem_wr_o       = mem_wr_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_o     = mem_data_q;
    assign access_count_o = acc_q;
    assign miss_count_o   = miss_q;

endmodule

// File: tb/tb_mem_arbiter_2port.sv
// Directed testbench for mem_arbiter_2port: a table of single transactions
// plus hand-written sequences for timeout, reset, alternation and saturation.
module tb_mem_arbiter_2port;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_i, req1_i, wr0_i, wr1_i;
    logic [AW-1:0] addr0_i, addr1_i;
    logic [DW-1:0] wdata0_i, wdata1_i;
    logic          ack0_o, ack1_o, err0_o, err1_o;
    logic [DW-1:0] rdata0_o, rdata1_o;
    logic          mem_start_o, mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_done_i;
    logic [DW-1:0] mem_rdata_i;
    logic          mem_miss_i;
    logic          clr_stats_i;
    logic [CW-1:0] access_count_o, miss_count_o;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter_2port #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0_i), .req1_i(req1_i), .wr0_i(wr0_i), .wr1_i(wr1_i),
        .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .ack0_o(ack0_o), .ack1_o(ack1_o), .err0_o(err0_o), .err1_o(err1_o),
        .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
        .mem_start_o(mem_start_o), .mem_wr_o(mem_wr_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_done_i(mem_done_i), .mem_rdata_i(mem_rdata_i), .mem_miss_i(mem_miss_i),
        .clr_stats_i(clr_stats_i),
        .access_count_o(access_count_o), .miss_count_o(miss_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rd;
        bit          miss;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        int          exp_acc;
        int          exp_miss;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one request, answer with mem_done on cycle dly after mem_start
    // (dly=0: never), return which response arrived and after how many cycles.
    task automatic txn(input bit port, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input int dly, input logic [31:0] rd,
                       input bit miss, input bit clr,
                       output bit got_ack, output bit got_err, output bit got_other,
                       output int lat);
        bit started;
        int extra;
        if (port) begin
            req1_i = 1'b1; wr1_i = wr; addr1_i = addr; wdata1_i = wdata;
        end else begin
            req0_i = 1'b1; wr0_i = wr; addr0_i = addr; wdata0_i = wdata;
        end
        started = 1'b0;
        for (int i = 0; i < 20 && !started; i++) begin
            @(negedge clk);
            if (mem_start_o) started = 1'b1;
        end
        chk("start_seen", 64'(started), 64'(1));
        chk("mem_addr", 64'(mem_addr_o), 64'(addr));
        chk("mem_wr", 64'(mem_wr_o), 64'(wr));
        chk("mem_data", 64'(mem_data_o), 64'(wdata));
        got_ack = 1'b0; got_err = 1'b0; got_other = 1'b0; lat = 0; extra = 0;
        for (int k = 1; k <= 200 && !(got_ack || got_err); k++) begin
            @(negedge clk);
            mem_done_i = 1'b0;
            if (mem_start_o) extra++;
            if (port ? ack1_o : ack0_o) got_ack = 1'b1;
            if (port ? err1_o : err0_o) got_err = 1'b1;
            if (port ? (ack0_o || err0_o) : (ack1_o || err1_o)) got_other = 1'b1;
            if (got_ack || got_err) lat = k;
            else if (k == dly) begin
                mem_done_i = 1'b1; mem_rdata_i = rd; mem_miss_i = miss;
            end
        end
        if (clr && got_ack) clr_stats_i = 1'b1;
        if (port) req1_i = 1'b0; else req0_i = 1'b0;
        @(negedge clk);
        clr_stats_i = 1'b0;
        chk("extra_start", 64'(extra), 64'(0));
    endtask

    task automatic quiet_window(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            mem_done_i = 1'b0;
            if (ack0_o || ack1_o || err0_o || err1_o || mem_start_o) seen++;
        end
        chk(name, 64'(seen), 64'(0));
    endtask

    initial begin
        bit a, e, o;
        int lat;
        int cnt0, cnt1;
        bit started;

        vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0, 1, 1};
        vecs[1] = '{1'b1, 1'b1, 32'h20, 32'h11111111, 1, 32'hBAD0BAD0, 1'b1, 32'hDEADBEEF, 32'h0, 2, 1};
        vecs[2] = '{1'b1, 1'b0, 32'h24, 32'h22222222, 1, 32'h12345678, 1'b0, 32'hDEADBEEF, 32'h12345678, 3, 1};
        vecs[3] = '{1'b0, 1'b1, 32'h30, 32'h33333333, 2, 32'hFFFFFFFF, 1'b0, 32'hDEADBEEF, 32'h12345678, 4, 1};
        vecs[4] = '{1'b0, 1'b0, 32'h34, 32'h44444444, 5, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'h12345678, 5, 2};
        // done on the last WAIT cycle: completes instead of timing out
        vecs[5] = '{1'b1, 1'b0, 32'h38, 32'h55555555, 64, 32'h0BADF00D, 1'b0, 32'hCAFEF00D, 32'h0BADF00D, 6, 2};

        rst_n = 1'b0;
        req0_i = 1'b0; req1_i = 1'b0; wr0_i = 1'b0; wr1_i = 1'b0;
        addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
        mem_done_i = 1'b0; mem_rdata_i = '0; mem_miss_i = 1'b0; clr_stats_i = 1'b0;
        #1;
        chk("rst_outputs", 64'({ack0_o, ack1_o, err0_o, err1_o, mem_start_o, mem_wr_o}), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr_o), 64'(0));
        chk("rst_rdata", 64'({rdata0_o, rdata1_o}), 64'(0));
        chk("rst_counts", 64'({access_count_o, miss_count_o}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of single transactions
        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dly,
                vecs[i].rd, vecs[i].miss, 1'b0, a, e, o, lat);
            chk($sformatf("v%0d_ack", i), 64'(a), 64'(1));
            chk($sformatf("v%0d_err", i), 64'(e), 64'(0));
            chk($sformatf("v%0d_other", i), 64'(o), 64'(0));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].dly + 1));
            chk($sformatf("v%0d_rdata0", i), 64'(rdata0_o), 64'(vecs[i].exp_rd0));
            chk($sformatf("v%0d_rdata1", i), 64'(rdata1_o), 64'(vecs[i].exp_rd1));
            chk($sformatf("v%0d_access", i), 64'(access_count_o), 64'(vecs[i].exp_acc));
            chk($sformatf("v%0d_miss", i), 64'(miss_count_o), 64'(vecs[i].exp_miss));
        end

        // Timeout on port 1: err 64 cycles after WAIT entry, counters frozen
        txn(1'b1, 1'b0, 32'h40, 32'h0, 0, 32'h0, 1'b0, 1'b0, a, e, o, lat);
        chk("to_err", 64'(e), 64'(1));
        chk("to_ack", 64'(a), 64'(0));
        chk("to_other", 64'(o), 64'(0));
        chk("to_latency", 64'(lat), 64'(TIMEOUT + 1));
        chk("to_access", 64'(access_count_o), 64'(6));
        chk("to_miss", 64'(miss_count_o), 64'(2));
        chk("to_rdata1", 64'(rdata1_o), 64'(32'h0BADF00D));
        repeat (3) @(negedge clk);
        mem_done_i = 1'b1; mem_rdata_i = 32'h99999999; mem_miss_i = 1'b1;
        quiet_window("to_late_done", 10);
        chk("to_late_rdata1", 64'(rdata1_o), 64'(32'h0BADF00D));

        // Reset asserted in the middle of WAIT
        req0_i = 1'b1; wr0_i = 1'b0; addr0_i = 32'h50; wdata0_i = 32'h0;
        started = 1'b0;
        for (int i = 0; i < 20 && !started; i++) begin
            @(negedge clk);
            if (mem_start_o) started = 1'b1;
        end
        chk("rw_start_seen", 64'(started), 64'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b0; req0_i = 1'b0;
        #1;
        chk("rw_outputs", 64'({ack0_o, ack1_o, err0_o, err1_o, mem_start_o, mem_wr_o}), 64'(0));
        chk("rw_mem_addr", 64'(mem_addr_o), 64'(0));
        chk("rw_rdata", 64'({rdata0_o, rdata1_o}), 64'(0));
        chk("rw_counts", 64'({access_count_o, miss_count_o}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_done_i = 1'b1; mem_rdata_i = 32'h77777777;
        quiet_window("rw_stray_done", 6);
        txn(1'b1, 1'b0, 32'h60, 32'h0, 2, 32'h600D600D, 1'b0, 1'b0, a, e, o, lat);
        chk("rw_after_ack", 64'(a), 64'(1));
        chk("rw_after_rdata1", 64'(rdata1_o), 64'(32'h600D600D));
        chk("rw_after_access", 64'(access_count_o), 64'(1));

        // Both ports requesting continuously, 4 writes each
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt0 = 0; cnt1 = 0;
        req0_i = 1'b1; wr0_i = 1'b1; addr0_i = 32'h100; wdata0_i = 32'hA000;
        req1_i = 1'b1; wr1_i = 1'b1; addr1_i = 32'h200; wdata1_i = 32'hB000;
        for (int j = 0; j < 8; j++) begin
            bit p;
            p = (j % 2) == 1;
            started = 1'b0;
            for (int i = 0; i < 20 && !started; i++) begin
                @(negedge clk);
                if (mem_start_o) started = 1'b1;
            end
            chk($sformatf("alt%0d_start", j), 64'(started), 64'(1));
            chk($sformatf("alt%0d_addr", j), 64'(mem_addr_o),
                64'(p ? 32'h200 + 32'(4 * cnt1) : 32'h100 + 32'(4 * cnt0)));
            chk($sformatf("alt%0d_wr", j), 64'(mem_wr_o), 64'(1));
            @(negedge clk);
            mem_done_i = 1'b1; mem_miss_i = 1'b1;
            @(negedge clk);
            mem_done_i = 1'b0;
            chk($sformatf("alt%0d_ack", j), 64'({ack0_o, ack1_o}), p ? 64'(1) : 64'(2));
            if (p) begin
                cnt1++;
                if (cnt1 == 4) req1_i = 1'b0;
                else begin addr1_i = 32'h200 + 32'(4 * cnt1); wdata1_i = 32'hB000 + 32'(cnt1); end
            end else begin
                cnt0++;
                if (cnt0 == 4) req0_i = 1'b0;
                else begin addr0_i = 32'h100 + 32'(4 * cnt0); wdata0_i = 32'hA000 + 32'(cnt0); end
            end
        end
        @(negedge clk);
        chk("alt_access", 64'(access_count_o), 64'(8));
        chk("alt_miss", 64'(miss_count_o), 64'(0));

        // Saturation with 4-bit counters, then clear in a RESP cycle
        for (int i = 0; i < 20; i++) begin
            txn(1'b0, 1'b0, 32'h300 + 32'(i), 32'h0, 1, 32'h1000 + 32'(i), 1'b1, 1'b0, a, e, o, lat);
            if (i == 14) chk("sat_miss_at15", 64'(miss_count_o), 64'(15));
        end
        chk("sat_access", 64'(access_count_o), 64'(15));
        chk("sat_miss", 64'(miss_count_o), 64'(15));
        chk("sat_rdata0", 64'(rdata0_o), 64'(32'h1000 + 19));
        txn(1'b0, 1'b0, 32'h400, 32'h0, 1, 32'h0, 1'b1, 1'b1, a, e, o, lat);
        chk("clr_ack", 64'(a), 64'(1));
        chk("clr_access", 64'(access_count_o), 64'(0));
        chk("clr_miss", 64'(miss_count_o), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_2port.md
Name: mem_arbiter_2port

Overview:
- Two-requester arbiter and sequencer in front of the shared cache/RAM memory port, e.g. instruction fetch on port 0 and data access on port 1.
- Serialises one transaction at a time: round-robin grant, one-cycle start pulse to memory, wait for completion with timeout, ack or error back to the granted requester.
- Keeps access and miss statistics counters for miss-rate measurement.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 64, maximum WAIT cycles before abort (must be ≥2)
- CW, 16, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  request from port 0 / 1; level, held with operands until ack or err
- wr0 / wr1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- err0 / err1  out  1  one-cycle timeout pulse
- rdata0 / rdata1  out  DW  read data, valid from the ack cycle, held until the next read ack on that port
- mem_start  out  1  one-cycle transaction start pulse
- mem_wr  out  1  operation to memory
- mem_addr  out  AW  address to memory
- mem_data  out  DW  write data to memory
- mem_done  in  1  one-cycle completion pulse from memory
- mem_rdata  in  DW  read data, valid with mem_done
- mem_miss  in  1  memory reports a cache miss, valid with mem_done
- clr_stats  in  1  synchronous clear of both counters
- access_count  out  CW  completed transactions
- miss_count  out  CW  completed reads with mem_miss=1

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer last=1 (port 0 wins the first tie), counters 0.
- Reset asserted mid-transaction: returns to IDLE immediately and mem_start drops. No ack or err is issued. A later mem_done is ignored.
- States: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - One request pending: grant it.
  - Both pending: grant the port opposite to last.
  - On grant, latch wr/addr/wdata of the granted port into mem_wr/mem_addr/mem_data, record the grant, and go to ISSUE.
  - No request: stay. mem_* outputs hold their last value.
- ISSUE (one cycle): mem_start=1. mem_done is ignored in this state. Clear the wait counter, then go to WAIT.
- WAIT:
  - mem_* held stable.
  - Counter increments each cycle.
  - mem_done=1: capture mem_rdata and mem_miss, go to RESP.
  - Otherwise, counter reaching TIMEOUT-1: go to ERR.
  - If mem_done arrives in the same cycle as the timeout, done wins.
- RESP (one cycle):
  - ackN=1 for the granted port.
  - For reads, rdataN is updated with the captured data; for writes, rdataN is unchanged.
  - last is set to the granted port. Go to IDLE.
- ERR (one cycle): errN=1, last is set to the granted port, go to IDLE. A late mem_done is ignored.
- Latency: req sampled at edge 0 → mem_start during cycle 1 → earliest mem_done in cycle 2 → ack in cycle 3. Minimum 4 cycles per transaction, including the return to IDLE.
- Back-to-back requests: if req is still high in the IDLE cycle after an ack, it is treated as a new transaction. With both ports continuously requesting, grants alternate 0,1,0,1.
- A requester dropping req after grant is a protocol violation. The transaction completes anyway and the ack is still issued.
- Statistics:
  - In the RESP cycle, access_count increments, and miss_count increments if the operation was a read with captured miss=1.
  - Both counters saturate at 2^CW-1.
  - clr_stats has priority over a same-cycle increment; the result is 0.
  - ERR does not count.

Test Plan:
- Single read on port 0, addr=0x10, mem_done 3 cycles after mem_start with mem_rdata=0xDEADBEEF and mem_miss=1 → one mem_start pulse, ack0 pulse, rdata0=0xDEADBEEF, access_count=1, miss_count=1, ack1 never asserted.
- Both ports request together from reset, each doing 4 writes → grant order 0,1,0,1,0,1,0,1; mem_addr always matches the granted port; access_count=8, miss_count=0.
- Read on port 1 with mem_done never returned, TIMEOUT=64 → err1 pulse 64 cycles after WAIT entry, no ack, counters unchanged. A mem_done 5 cycles later is ignored and the FSM stays in IDLE.
- mem_done in the same cycle as the timeout → ack issued, no err.
- rst_n pulled low during WAIT → all outputs 0 asynchronously. After release, a stray mem_done produces no ack. A following port-1 request completes normally.
- Saturation test with CW=4: perform 20 reads with miss=1 → both counters stop at 15. Assert clr_stats in a RESP cycle → both counters read 0 on the next cycle.
